// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, reads instruction memory, hands words to decode.
// Optional misaligned-redirect trap (ERR state) is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MEM_LAT  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               fetch_enable,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               misalign_trap
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] S_ERR  = 3'd4;
`endif

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic               misalign_q, misalign_d;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    lat_cnt_d     = lat_cnt_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
`endif

    case (state_q)
      S_IDLE: if (fetch_enable) state_d = S_REQ;
      S_REQ: begin
        lat_cnt_d = LAT_INIT;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          instr_d       = mem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(4);
          state_d       = S_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = fetch_enable ? S_REQ : S_IDLE;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_ERR: state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above; a word captured this cycle is thrown away.
    if (redirect_valid) begin
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = S_ERR;
      end else begin
        misalign_d = 1'b0;
        state_d    = fetch_enable ? S_REQ : S_IDLE;
      end
`else
      pc_d    = redirect_pc & ~ADDR_W'(3);
      state_d = fetch_enable ? S_REQ : S_IDLE;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      lat_cnt_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      lat_cnt_q     <= lat_cnt_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign mem_rd      = (state_q == S_REQ);
  assign mem_raddr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = misalign_q;
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: DUT a (MEM_LAT=1) checked by a monitor, DUT b (MEM_LAT=3) directed.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        a_fe = 1'b0, a_rd, a_redir = 1'b0, a_valid, a_ready = 1'b1, a_trap;
  logic [63:0] a_raddr, a_redir_pc = '0, a_ipc;
  logic [31:0] a_rdata = '0, a_instr;

  logic        b_fe = 1'b0, b_rd, b_redir = 1'b0, b_valid, b_trap;
  logic [63:0] b_raddr, b_redir_pc = '0, b_ipc;
  logic [31:0] b_rdata = '0, b_instr;

  logic [63:0] rd_q[$];
  logic [63:0] out_q[$];
  logic [63:0] mon_e;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0), .MEM_LAT(1)) u_dut (
    .CLK(CLK), .RST(RST), .fetch_enable(a_fe), .mem_rd(a_rd), .mem_raddr(a_raddr),
    .mem_rdata(a_rdata), .redirect_valid(a_redir), .redirect_pc(a_redir_pc),
    .instr_valid(a_valid), .instr_ready(a_ready), .instr(a_instr), .instr_pc(a_ipc),
    .misalign_trap(a_trap));

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0), .MEM_LAT(3)) u_dut_lat3 (
    .CLK(CLK), .RST(RST), .fetch_enable(b_fe), .mem_rd(b_rd), .mem_raddr(b_raddr),
    .mem_rdata(b_rdata), .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
    .instr_valid(b_valid), .instr_ready(1'b1), .instr(b_instr), .instr_pc(b_ipc),
    .misalign_trap(b_trap));

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  always @(posedge CLK) if (a_rd) a_rdata <= memf(a_raddr);
  always @(posedge CLK) if (b_rd) b_rdata <= memf(b_raddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every read strobe and every transfer on DUT a must match the next queued expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (a_rd) begin
        if (rd_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_mem_rd: got addr %h expected no read", a_raddr);
        end else begin
          mon_e = rd_q.pop_front();
          chk("mem_raddr", a_raddr, mon_e);
        end
      end
      if (a_valid && a_ready) begin
        if (out_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_instr: got pc %h expected no transfer", a_ipc);
        end else begin
          mon_e = out_q.pop_front();
          chk("instr_pc", a_ipc, mon_e);
          chk("instr", {32'h0, a_instr}, {32'h0, memf(mon_e)});
        end
      end
    end
  end

  initial begin
    // Reset state
    step(2);
    chk("rst_mem_rd", {63'h0, a_rd}, 64'h0);
    chk("rst_mem_raddr", a_raddr, 64'h0);
    chk("rst_valid", {63'h0, a_valid}, 64'h0);
    chk("rst_instr", {32'h0, a_instr}, 64'h0);
    chk("rst_instr_pc", a_ipc, 64'h0);
    chk("rst_trap", {63'h0, a_trap}, 64'h0);

    // Sequential fetch 0,4,8; first valid after the third edge
    a_fe = 1'b1;
    rd_q.push_back(64'h0); rd_q.push_back(64'h4); rd_q.push_back(64'h8);
    out_q.push_back(64'h0); out_q.push_back(64'h4); out_q.push_back(64'h8);
    RST = 1'b0;
    step(2);
    chk("valid_before_edge3", {63'h0, a_valid}, 64'h0);
    step(1);
    chk("valid_at_edge3", {63'h0, a_valid}, 64'h1);
    chk("first_instr_pc", a_ipc, 64'h0);
    step(4);
    a_fe = 1'b0;
    step(4);

    // Stall in HOLD for 5 cycles
    a_ready = 1'b0; a_fe = 1'b1;
    rd_q.push_back(64'hC); rd_q.push_back(64'h10);
    out_q.push_back(64'hC); out_q.push_back(64'h10);
    for (int i = 0; i < 20 && !a_valid; i++) step(1);
    chk("stall_valid_seen", {63'h0, a_valid}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_no_mem_rd", {63'h0, a_rd}, 64'h0);
      chk("stall_instr_pc", a_ipc, 64'hC);
      chk("stall_instr", {32'h0, a_instr}, {32'h0, memf(64'hC)});
    end
    a_ready = 1'b1;
    step(1);
    chk("post_stall_rd", {63'h0, a_rd}, 64'h1);
    chk("post_stall_raddr", a_raddr, 64'h10);
    a_fe = 1'b0;
    step(4);

    // Redirect to top of address space; pc+4 wraps to 0
    a_fe = 1'b1; a_redir = 1'b1; a_redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    rd_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); rd_q.push_back(64'h0);
    out_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); out_q.push_back(64'h0);
    step(1);
    a_redir = 1'b0;
    step(3);
    chk("wrap_rd", {63'h0, a_rd}, 64'h1);
    chk("wrap_raddr", a_raddr, 64'h0);
    a_fe = 1'b0;
    step(4);

    // Misaligned redirect
    a_fe = 1'b1; a_redir = 1'b1; a_redir_pc = 64'h102;
`ifdef FETCH_MISALIGN_TRAP_EN
    step(1);
    a_redir = 1'b0;
    chk("trap_set", {63'h0, a_trap}, 64'h1);
    chk("trap_no_rd", {63'h0, a_rd}, 64'h0);
    step(3);
    chk("trap_held", {63'h0, a_trap}, 64'h1);
    chk("trap_valid_low", {63'h0, a_valid}, 64'h0);
    a_redir = 1'b1; a_redir_pc = 64'h200;
    rd_q.push_back(64'h200); out_q.push_back(64'h200);
    step(1);
    a_redir = 1'b0;
    chk("trap_cleared", {63'h0, a_trap}, 64'h0);
    chk("trap_exit_raddr", a_raddr, 64'h200);
`else
    rd_q.push_back(64'h100); out_q.push_back(64'h100);
    step(1);
    a_redir = 1'b0;
    chk("noalign_trap", {63'h0, a_trap}, 64'h0);
    chk("noalign_raddr", a_raddr, 64'h100);
`endif
    chk("misalign_rd", {63'h0, a_rd}, 64'h1);
    a_fe = 1'b0;
    step(4);

    // MEM_LAT=3 instance: latency and redirect during WAIT
    b_fe = 1'b1;
    step(1);
    chk("b_req_rd", {63'h0, b_rd}, 64'h1);
    chk("b_req_raddr", b_raddr, 64'h0);
    step(3);
    chk("b_valid_early", {63'h0, b_valid}, 64'h0);
    step(1);
    chk("b_valid_lat", {63'h0, b_valid}, 64'h1);
    chk("b_instr_pc0", b_ipc, 64'h0);
    chk("b_instr0", {32'h0, b_instr}, {32'h0, memf(64'h0)});
    step(1);
    chk("b_req2_raddr", b_raddr, 64'h4);
    step(1);
    b_redir = 1'b1; b_redir_pc = 64'h100;
    step(1);
    b_redir = 1'b0; b_fe = 1'b0;
    chk("b_redir_raddr", b_raddr, 64'h100);
    chk("b_redir_valid", {63'h0, b_valid}, 64'h0);
    for (int i = 0; i < 12 && !b_valid; i++) step(1);
    chk("b_redir_instr_pc", b_ipc, 64'h100);
    chk("b_redir_instr", {32'h0, b_instr}, {32'h0, memf(64'h100)});
    step(2);

    // Asynchronous reset in the middle of WAIT
    a_fe = 1'b1; a_redir = 1'b1; a_redir_pc = 64'h300;
    rd_q.push_back(64'h300);
    step(1);
    a_redir = 1'b0; a_fe = 1'b0;
    step(1);
    #2 RST = 1'b1;
    #1;
    chk("async_valid", {63'h0, a_valid}, 64'h0);
    chk("async_rd", {63'h0, a_rd}, 64'h0);
    chk("async_raddr", a_raddr, 64'h0);
    step(2);
    RST = 1'b0;
    step(3);
    chk("post_rst_valid", {63'h0, a_valid}, 64'h0);

    chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
    chk("out_q_drained", 64'(out_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
